// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_e;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_CSUM = 2'b10;

   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word assembler; pulses word_valid the cycle after the 4th byte.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  byte_in,
   input  logic        byte_en,
   input  logic        clear,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0] cnt;

   // First byte ends up in bits [7:0] after four right-shifts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= 2'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            cnt  <= 2'd0;
            word <= 32'd0;
         end else if (byte_en) begin
            word       <= {byte_in, word[31:8]};
            cnt        <= cnt + 2'd1;
            word_valid <= (cnt == 2'(BYTES_PER_WORD - 1));
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction RAM while holding the CPU in reset.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic          err,
   output logic [1:0]    err_code,
   output logic [15:0]   words_loaded
);

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   state_e      state, state_n;
   logic [15:0] len;
   logic [15:0] len_n;
   logic [7:0]  csum;
   logic [1:0]  bcnt;
   logic        launch;
   logic        data_acc;
   logic        word_done;
   logic        last_word;

   assign len_n     = {rx_data, len[7:0]};
   assign data_acc  = (state == S_DATA) && rx_valid;
   assign word_done = data_acc && (bcnt == 2'(BYTES_PER_WORD - 1));
   assign last_word = (words_loaded == len - 16'd1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n  = state;
      rx_ready = 1'b0;
      cpu_hold = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      launch   = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            done = (state == S_DONE);
            err  = (state == S_ERR);
            if (start) begin
               launch  = 1'b1;
               state_n = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            rx_ready = 1'b1;
            cpu_hold = 1'b1;
            if (rx_valid) state_n = S_LEN_HI;
         end
         S_LEN_HI: begin
            rx_ready = 1'b1;
            cpu_hold = 1'b1;
            if (rx_valid) begin
               if (len_n > DEPTH_W)     state_n = S_ERR;
               else if (len_n == 16'd0) state_n = S_CSUM;
               else                     state_n = S_DATA;
            end
         end
         S_DATA: begin
            rx_ready = 1'b1;
            cpu_hold = 1'b1;
            if (word_done && last_word) state_n = S_CSUM;
         end
         S_CSUM: begin
            rx_ready = 1'b1;
            cpu_hold = 1'b1;
            if (rx_valid) state_n = (rx_data == csum) ? S_DONE : S_ERR;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Address and word count advance on the 4th-byte handshake, lining up with the packer's write pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len          <= 16'd0;
         csum         <= 8'd0;
         bcnt         <= 2'd0;
         words_loaded <= 16'd0;
         imem_addr    <= '0;
         err_code     <= ERR_NONE;
      end else begin
         if (launch) begin
            csum         <= 8'd0;
            bcnt         <= 2'd0;
            words_loaded <= 16'd0;
            err_code     <= ERR_NONE;
         end
         if (state == S_LEN_LO && rx_valid) len[7:0] <= rx_data;
         if (state == S_LEN_HI && rx_valid) begin
            len[15:8] <= rx_data;
            if (len_n > DEPTH_W) err_code <= ERR_LEN;
         end
         if (data_acc) begin
            csum <= csum ^ rx_data;
            bcnt <= bcnt + 2'd1;
         end
         if (word_done) begin
            imem_addr    <= AW'({words_loaded, 2'b00});
            words_loaded <= words_loaded + 16'd1;
         end
         if (state == S_CSUM && rx_valid && rx_data != csum) err_code <= ERR_CSUM;
      end
   end

   byte_packer u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .byte_in    (rx_data),
      .byte_en    (data_acc),
      .clear      (launch),
      .word       (imem_wdata),
      .word_valid (imem_we)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image-level model predicts writes and final status.
module tb_imem_loader;

   localparam int DEPTH = 16;
   localparam int AW    = 32;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          err;
   logic [1:0]    err_code;
   logic [15:0]   words_loaded;

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .err          (err),
      .err_code     (err_code),
      .words_loaded (words_loaded)
   );

   typedef struct {
      int          cyc;
      logic [31:0] addr;
      logic [31:0] data;
      logic [15:0] wl;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   logic [7:0]  img[$];
   int          cyc;
   int          checks;
   int          errors;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Every cycle: a write happens exactly when the model scheduled one.
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         chk("imem_we", {31'd0, imem_we}, 32'd1);
         chk("imem_addr", imem_addr, exp_q[0].addr);
         chk("imem_wdata", imem_wdata, exp_q[0].data);
         chk("words_loaded_at_we", {16'd0, words_loaded}, {16'd0, exp_q[0].wl});
         void'(exp_q.pop_front());
      end else begin
         chk("imem_we_idle", {31'd0, imem_we}, 32'd0);
      end
      if (imem_we) begin
         wr_addr_log.push_back(imem_addr);
         wr_data_log.push_back(imem_wdata);
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit with_start, output int e);
      rx_data  = b;
      rx_valid = 1'b1;
      start    = with_start;
      @(negedge clk);
      chk("rx_ready_busy", {31'd0, rx_ready}, 32'd1);
      chk("cpu_hold_busy", {31'd0, cpu_hold}, 32'd1);
      @(posedge clk);
      e = cyc;
      #1;
      start = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("start_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("start_rx_ready", {31'd0, rx_ready}, 32'd1);
      chk("start_status", {27'd0, done, err, err_code, |words_loaded}, 32'd0);
   endtask

   // Model: decode the image by its format and predict writes and outcome.
   task automatic run_image(input int pause_at, input int start_at);
      int          n;
      int          nsend;
      int          e;
      int          base;
      bit          len_err;
      bit          ok;
      logic [7:0]  sum;
      n       = {img[1], img[0]};
      len_err = (n > DEPTH);
      nsend   = len_err ? 2 : 2 + 4 * n + 1;
      sum     = 8'h00;
      for (int i = 0; i < nsend; i++) begin
         if (i == pause_at) begin
            rx_valid = 1'b0;
            repeat (5) @(posedge clk);
            #1;
         end
         send_byte(img[i], (i == start_at), e);
         if (i >= 2 && i < 2 + 4 * n) begin
            sum = sum ^ img[i];
            if ((i - 2) % 4 == 3) begin
               base = i - 3;
               exp_q.push_back('{cyc: e + 1,
                                 addr: 32'((i - 2) / 4 * 4),
                                 data: {img[base+3], img[base+2], img[base+1], img[base]},
                                 wl: 16'((i - 2) / 4 + 1)});
            end
         end
      end
      rx_valid = 1'b0;
      ok = !len_err && (img[2 + 4 * n] == sum);
      chk("end_done", {31'd0, done}, {31'd0, ok});
      chk("end_err", {31'd0, err}, {31'd0, !ok});
      chk("end_err_code", {30'd0, err_code}, len_err ? 32'd1 : (ok ? 32'd0 : 32'd2));
      chk("end_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      chk("end_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("end_words_loaded", {16'd0, words_loaded}, len_err ? 32'd0 : 32'(n));
      @(negedge clk);
      chk("pending_writes", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic load_img_a(input logic [7:0] last);
      img = '{8'h02, 8'h00, 8'h33, 8'h02, 8'h11, 8'h00, 8'hB3, 8'h02, 8'h11, 8'h40, last};
   endtask

   initial begin
      int e;
      checks   = 0;
      errors   = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #2;
      chk("reset_outputs", {rx_ready, imem_we, cpu_hold, done, err, err_code, words_loaded},
          32'd0);
      chk("reset_addr", imem_addr, 32'd0);
      chk("reset_wdata", imem_wdata, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Two-word image, good checksum
      load_img_a(8'hC0);
      wr_addr_log.delete();
      wr_data_log.delete();
      do_start();
      run_image(-1, -1);
      chk("s1_nwrites", wr_addr_log.size(), 32'd2);
      if (wr_addr_log.size() == 2) begin
         chk("s1_w0_addr", wr_addr_log[0], 32'h0000_0000);
         chk("s1_w0_data", wr_data_log[0], 32'h0011_0233);
         chk("s1_w1_addr", wr_addr_log[1], 32'h0000_0004);
         chk("s1_w1_data", wr_data_log[1], 32'h4011_02B3);
      end
      chk("s1_done_lit", {30'd0, done, err}, 32'd2);

      // Bad checksum
      load_img_a(8'hC1);
      wr_addr_log.delete();
      do_start();
      run_image(-1, -1);
      chk("s2_nwrites", wr_addr_log.size(), 32'd2);
      chk("s2_err_code_lit", {30'd0, err_code}, 32'd2);

      // Restart after error, with a stray start in DATA
      load_img_a(8'hC0);
      do_start();
      run_image(-1, 5);
      chk("s6_done_lit", {31'd0, done}, 32'd1);

      // Length too long
      img = '{8'h11, 8'h00};
      do_start();
      run_image(-1, -1);
      rx_valid = 1'b1;
      rx_data  = 8'h5A;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("s3_rx_ready", {31'd0, rx_ready}, 32'd0);
      end
      rx_valid = 1'b0;
      chk("s3_err_code_lit", {30'd0, err_code}, 32'd1);
      @(posedge clk);
      #1;

      // Empty image
      img = '{8'h00, 8'h00, 8'h00};
      wr_addr_log.delete();
      do_start();
      run_image(-1, -1);
      chk("s4_nwrites", wr_addr_log.size(), 32'd0);

      // Back-pressure mid-word
      load_img_a(8'hC0);
      wr_addr_log.delete();
      wr_data_log.delete();
      do_start();
      run_image(4, -1);
      chk("s4b_nwrites", wr_addr_log.size(), 32'd2);
      if (wr_data_log.size() == 2) begin
         chk("s4b_w0_data", wr_data_log[0], 32'h0011_0233);
         chk("s4b_w1_data", wr_data_log[1], 32'h4011_02B3);
      end

      // Reset after the 6th byte
      load_img_a(8'hC0);
      do_start();
      for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0, e);
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      chk("s5_async_outputs", {rx_ready, imem_we, cpu_hold, done, err, err_code, words_loaded},
          32'd0);
      chk("s5_async_addr", imem_addr, 32'd0);
      chk("s5_async_wdata", imem_wdata, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h33;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("s5_idle_ready", {29'd0, rx_ready, cpu_hold, |words_loaded}, 32'd0);
      end
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
      do_start();
      run_image(-1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It is the other end of the read-only instruction fetch path.
- Accepts a byte stream over a valid/ready handshake, e.g. from a UART receiver.
- Assembles little-endian 32-bit instruction words and writes them sequentially into instruction RAM, starting at byte address 0.
- Holds the CPU in reset while loading.
- Validates the image length and an XOR checksum, and reports done or error.

Parameters:
DEPTH, 16, instruction memory size in 32-bit words; maximum loadable word count.
AW, 32, byte-address width of the write port; matches the fetch address width.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins a load from IDLE, DONE or ERR; ignored while busy
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts byte; transfer when rx_valid && rx_ready
imem_we  out  1  instruction RAM write strobe, 1 cycle per word
imem_addr  out  AW  byte address of write, word-aligned ([1:0]=0); RAM indexes addr[AW-1:2]
imem_wdata  out  32  instruction word
cpu_hold  out  1  high while loading; drives CPU core reset
done  out  1  image loaded and checksum OK; sticky until next start
err  out  1  load failed; sticky until next start
err_code  out  2  00 none, 01 length > DEPTH, 10 checksum mismatch
words_loaded  out  16  count of words written in the current/last load

Behaviour:
- Reset is asynchronous and active-low on reset_n. While reset_n is low:
  - state=IDLE;
  - all outputs 0: rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err, err_code, words_loaded;
  - internal byte counter, word counter and checksum are cleared.
- Reset mid-load aborts the load. Partially written RAM contents are left as-is. The loader does not restart until a new start.
- Image format, in byte order:
  - LEN_LO, LEN_HI: 16-bit word count N;
  - N×4 data bytes, each word little-endian (first byte = bits [7:0]);
  - CSUM: XOR of all data bytes only; length bytes are excluded.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
  - IDLE/DONE/ERR + start → LEN_LO. On this transition, clear done, err, err_code, words_loaded, checksum and byte counter. Set cpu_hold=1.
  - LEN_LO: on handshake, latch low byte → LEN_HI.
  - LEN_HI: on handshake, N is known.
    - N > DEPTH → ERR with err_code=01.
    - N == 0 → CSUM.
    - Otherwise → DATA.
  - DATA: each handshake shifts the byte into the word assembler and XORs it into the checksum.
    - On the 4th byte of a word: the next cycle drives imem_we=1, imem_wdata=the word, imem_addr=words_loaded*4. words_loaded increments in that same cycle.
    - After the 4th byte of word N-1 → CSUM.
  - CSUM: on handshake, the byte equals the running checksum → DONE; otherwise → ERR with err_code=10.
  - DONE: cpu_hold=0, done=1.
  - ERR: cpu_hold=0, err=1.
- rx_ready = 1 in LEN_LO, LEN_HI, DATA, CSUM; 0 in IDLE, DONE, ERR.
- The loader never stalls the stream: a byte may be accepted in the same cycle as the imem_we pulse of the previous word.
- imem_we is registered and high for exactly one cycle per word. Write latency is 1 cycle after the 4th-byte handshake.
- cpu_hold asserts the cycle after start is sampled. It deasserts the cycle after the final CSUM handshake, or the cycle after the LEN_HI handshake on a length error.
- start while in LEN_LO..CSUM is ignored.
- rx_valid low just pauses the load; there is no timeout.
- The address is N-bounded, so it cannot wrap: the highest address written is (DEPTH-1)*4.

Decomposition:
- Package imem_loader_pkg:
  - state_e enum;
  - err_code constants ERR_NONE=2'b00, ERR_LEN=2'b01, ERR_CSUM=2'b10;
  - BYTES_PER_WORD=4.
- Sub-module byte_packer:
  - 2-bit byte counter plus 32-bit shift register;
  - inputs: byte, byte_en, clear;
  - outputs: word, word_valid (1-cycle pulse).
- The FSM, address/word counters and checksum stay in imem_loader.

Test Plan:
1. Load two words. start, then bytes 02 00 | 33 02 11 00 | B3 02 11 40 | C0 → two writes, each 1 cycle after its 4th byte:
   - addr 0x0 data 0x00110233;
   - addr 0x4 data 0x401102B3.
   Then done=1, err=0, words_loaded=2, cpu_hold falls after the C0 byte.
2. Bad checksum. Same image with final byte C1 → both writes occur, then err=1, err_code=10, done=0, cpu_hold=0.
3. Length too long. Length bytes 11 00 (N=17, DEPTH=16) → ERR with err_code=01 right after LEN_HI, no imem_we, rx_ready=0.
4. Empty image and back-pressure. Length 00 00, CSUM 00 → DONE with no writes. Separately, drop rx_valid for 5 cycles mid-word in scenario 1 → identical writes, only delayed.
5. Reset mid-load. Assert reset_n=0 after the 6th byte → all outputs 0 immediately (async). After release the loader stays in IDLE and ignores rx_valid (rx_ready=0) until start.
6. Restart. start pulsed during DATA is ignored. start after ERR clears err/err_code and scenario 1 completes normally.
